unit_cmd_master: RTL



---
 rtl/unit_cmd_master_pkg.sv | 31 +++
 rtl/unit_cmd_master_word_buf.sv | 60 ++++++
 rtl/unit_cmd_master.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/unit_cmd_master_pkg.sv
// Shared types for the unit command bus initiator: FSM states, response header
// layout and default buffer depths.
package unit_cmd_master_pkg;

  localparam int DEF_MAX_ARGS   = 8;
  localparam int DEF_MAX_PARAMS = 8;
  localparam int TMO_BITS       = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_EXEC,
    S_GRANT,
    S_INVOL,
    S_RSP_HDR,
    S_RSP_DATA
  } state_t;

  // Header word carries only the response code; the count travels on a sideband.
  typedef struct packed {
    logic [31:0] code;
  } rsp_hdr_t;

  function automatic logic [31:0] hdr_word(logic [31:0] code);
    rsp_hdr_t h;
    h.code = code;
    return h;
  endfunction

endpackage

// File: rtl/unit_cmd_master_word_buf.sv
// Write-once-per-frame word buffer: write pointer doubles as the fill count,
// read port is a mux on the registered read pointer that returns 0 past the fill.
module word_buf
  import unit_cmd_master_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_ARGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic                     rd_rst,
  input  logic                     rd_inc,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   rd_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] rd_ptr_reg;
  logic [31:0]   words [DEPTH];

  assign full   = (count_reg == CW'(DEPTH));
  assign count  = count_reg;
  assign rd_ptr = rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en && !full)
        count_reg <= count_reg + CW'(1);
      if (rd_rst)
        rd_ptr_reg <= '0;
      else if (rd_inc)
        rd_ptr_reg <= rd_ptr_reg + CW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [31:0] word_reg;
      always_ff @(posedge clk) begin
        if (wr_en && !full && count_reg == CW'(gi))
          word_reg <= wr_data;
      end
      assign words[gi] = word_reg;
    end
  endgenerate

  assign rd_data = (rd_ptr_reg < count_reg) ? words[rd_ptr_reg[IW-1:0]] : 32'd0;

endmodule

// File: rtl/unit_cmd_master.sv
// Unit command bus initiator: loads arguments, issues a command to one unit,
// collects its parameter burst and frames it as a response; arbitrates involuntary reports.
module unit_cmd_master
  import unit_cmd_master_pkg::*;
#(
  parameter int CMD_BITS   = 8,
  parameter int MAX_ARGS   = DEF_MAX_ARGS,
  parameter int MAX_PARAMS = DEF_MAX_PARAMS,
  parameter int TIMEOUT    = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [CMD_BITS-1:0]           in_cmd,
  input  logic [$clog2(MAX_ARGS):0]     in_nargs,
  output logic                          in_accept,
  input  logic [31:0]                   af_data,
  input  logic                          af_empty,
  output logic                          af_rd,
  output logic [CMD_BITS-1:0]           cmd,
  output logic                          cmd_ready,
  output logic [31:0]                   arg_data,
  input  logic                          arg_advance,
  input  logic                          cmd_done,
  input  logic [31:0]                   param_data,
  input  logic                          param_write,
  input  logic                          invol_req,
  output logic                          invol_grant,
  output logic [31:0]                   rsp_data,
  output logic                          rsp_valid,
  output logic                          rsp_last,
  input  logic                          rsp_ready,
  output logic [$clog2(MAX_PARAMS):0]   rsp_nparams,
  output logic                          timeout_err,
  output logic                          param_overflow,
  output logic                          busy
);

  localparam int AW = $clog2(MAX_ARGS) + 1;
  localparam int PW = $clog2(MAX_PARAMS) + 1;

  state_t                state_reg;
  logic [CMD_BITS-1:0]   cmd_reg;
  logic [AW-1:0]         nargs_reg;
  logic                  ret_issue_reg;
  logic [TMO_BITS-1:0]   tmo_reg;
  logic                  in_accept_reg, cmd_ready_reg, invol_grant_reg;
  logic [31:0]           rsp_data_reg;
  logic                  rsp_valid_reg, rsp_last_reg;
  logic [PW-1:0]         rsp_nparams_reg;
  logic                  timeout_err_reg, overflow_reg, busy_reg;

  logic                  arg_clr, load_pop, arg_rd_rst, arg_rd_inc, arg_full;
  logic [31:0]           arg_rd_data;
  logic [AW-1:0]         arg_cnt, arg_rd_ptr;
  logic                  prm_clr, prm_wr, prm_rd_inc, prm_full;
  logic [31:0]           prm_rd_data;
  logic [PW-1:0]         prm_cnt, prm_rd_ptr, n_cap;
  logic                  collecting, tmo_hit;

  always_comb begin
    collecting = (state_reg == S_EXEC) || (state_reg == S_INVOL);
    load_pop   = (state_reg == S_LOAD) && !af_empty && !arg_full && (arg_cnt < nargs_reg);
    arg_clr    = (state_reg == S_IDLE) && !invol_req && in_valid;
    arg_rd_rst = (state_reg == S_ISSUE);
    // Argument pointer saturates at nargs so arg_data falls to 0 after the last word.
    arg_rd_inc = (cmd_ready_reg || state_reg == S_EXEC) && arg_advance && (arg_rd_ptr < arg_cnt);
    prm_clr    = ((state_reg == S_IDLE) && (invol_req || in_valid)) || (state_reg == S_ISSUE);
    prm_wr     = collecting && param_write;
    prm_rd_inc = rsp_ready && ((state_reg == S_RSP_HDR) ||
                               (state_reg == S_RSP_DATA && !rsp_last_reg));
    n_cap      = prm_cnt + PW'(param_write && !prm_full);
    tmo_hit    = (tmo_reg == TMO_BITS'(TIMEOUT - 1));
  end

  word_buf #(.DEPTH(MAX_ARGS)) u_arg_buf (
    .clk(clk), .rst_n(rst_n), .clr(arg_clr), .wr_en(load_pop), .wr_data(af_data),
    .rd_rst(arg_rd_rst), .rd_inc(arg_rd_inc), .rd_data(arg_rd_data),
    .rd_ptr(arg_rd_ptr), .count(arg_cnt), .full(arg_full)
  );

  word_buf #(.DEPTH(MAX_PARAMS)) u_prm_buf (
    .clk(clk), .rst_n(rst_n), .clr(prm_clr), .wr_en(prm_wr), .wr_data(param_data),
    .rd_rst(1'b0), .rd_inc(prm_rd_inc), .rd_data(prm_rd_data),
    .rd_ptr(prm_rd_ptr), .count(prm_cnt), .full(prm_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      cmd_reg         <= '0;
      nargs_reg       <= '0;
      ret_issue_reg   <= 1'b0;
      tmo_reg         <= '0;
      in_accept_reg   <= 1'b0;
      cmd_ready_reg   <= 1'b0;
      invol_grant_reg <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_last_reg    <= 1'b0;
      rsp_nparams_reg <= '0;
      timeout_err_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      in_accept_reg   <= 1'b0;
      cmd_ready_reg   <= 1'b0;
      invol_grant_reg <= 1'b0;
      if (prm_wr && prm_full)
        overflow_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (invol_req) begin
            invol_grant_reg <= 1'b1;
            ret_issue_reg   <= 1'b0;
            tmo_reg         <= '0;
            busy_reg        <= 1'b1;
            state_reg       <= S_INVOL;
          end else if (in_valid) begin
            cmd_reg       <= in_cmd;
            nargs_reg     <= in_nargs;
            in_accept_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= (in_nargs == '0) ? S_ISSUE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_pop && (arg_cnt + AW'(1) == nargs_reg))
            state_reg <= S_ISSUE;
        end
        S_ISSUE: begin
          tmo_reg <= '0;
          if (invol_req) begin
            invol_grant_reg <= 1'b1;
            ret_issue_reg   <= 1'b1;
            state_reg       <= S_INVOL;
          end else begin
            cmd_ready_reg <= 1'b1;
            state_reg     <= S_EXEC;
          end
        end
        S_EXEC, S_INVOL: begin
          if (cmd_done) begin
            if (n_cap == '0) begin
              state_reg     <= ret_issue_reg ? S_ISSUE : S_IDLE;
              busy_reg      <= ret_issue_reg;
              ret_issue_reg <= 1'b0;
            end else begin
              rsp_data_reg    <= hdr_word(param_data);
              rsp_nparams_reg <= n_cap;
              rsp_valid_reg   <= 1'b1;
              rsp_last_reg    <= 1'b0;
              state_reg       <= S_RSP_HDR;
            end
          end else if (tmo_hit) begin
            timeout_err_reg <= 1'b1;
            ret_issue_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            state_reg       <= S_IDLE;
          end else begin
            tmo_reg <= tmo_reg + TMO_BITS'(1);
          end
        end
        S_RSP_HDR: begin
          if (rsp_ready) begin
            rsp_data_reg <= prm_rd_data;
            rsp_last_reg <= (prm_rd_ptr + PW'(1) == prm_cnt);
            state_reg    <= S_RSP_DATA;
          end
        end
        S_RSP_DATA: begin
          if (rsp_ready) begin
            if (rsp_last_reg) begin
              rsp_data_reg    <= '0;
              rsp_valid_reg   <= 1'b0;
              rsp_last_reg    <= 1'b0;
              rsp_nparams_reg <= '0;
              state_reg       <= ret_issue_reg ? S_ISSUE : S_IDLE;
              busy_reg        <= ret_issue_reg;
              ret_issue_reg   <= 1'b0;
            end else begin
              rsp_data_reg <= prm_rd_data;
              rsp_last_reg <= (prm_rd_ptr + PW'(1) == prm_cnt);
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign in_accept      = in_accept_reg;
  assign af_rd          = load_pop;
  assign cmd            = cmd_reg;
  assign cmd_ready      = cmd_ready_reg;
  assign arg_data       = arg_rd_data;
  assign invol_grant    = invol_grant_reg;
  assign rsp_data       = rsp_data_reg;
  assign rsp_valid      = rsp_valid_reg;
  assign rsp_last       = rsp_last_reg;
  assign rsp_nparams    = rsp_nparams_reg;
  assign timeout_err    = timeout_err_reg;
  assign param_overflow = overflow_reg;
  assign busy           = busy_reg;

endmodule
